// File: rtl/marker_row_tracker_if.sv
// marker_row_tracker_if
// Bundles the per-line results from count_flips (inputs to the tracker) and
// the marker candidate outputs of marker_row_tracker.
//   frame_start_in      : one-cycle pulse at start of frame
//   done_in             : count_flips done level, line valid on rising edge
//   number_of_flips_in  : flips in current line
//   coord_in            : horizontal coordinate of the line's pattern
//   nt_probability_in   : line score, higher is better
//   marker_valid_out    : one-cycle pulse, marker fields updated
//   marker_top_out      : first line index of run
//   marker_bottom_out   : last line index of run
//   marker_x_out        : (min_coord + max_coord) >> 1 over run
//   marker_score_out    : max nt_probability over run
//   marker_count_out    : markers emitted this frame, saturating at 15
// master = line source / marker consumer, slave = the tracker.
interface marker_row_tracker_if;
    logic        frame_start_in;
    logic        done_in;
    logic [3:0]  number_of_flips_in;
    logic [10:0] coord_in;
    logic [10:0] nt_probability_in;

    logic        marker_valid_out;
    logic [10:0] marker_top_out;
    logic [10:0] marker_bottom_out;
    logic [10:0] marker_x_out;
    logic [10:0] marker_score_out;
    logic [3:0]  marker_count_out;

    modport master (
        output frame_start_in, done_in, number_of_flips_in, coord_in, nt_probability_in,
        input  marker_valid_out, marker_top_out, marker_bottom_out, marker_x_out,
               marker_score_out, marker_count_out
    );

    modport slave (
        input  frame_start_in, done_in, number_of_flips_in, coord_in, nt_probability_in,
        output marker_valid_out, marker_top_out, marker_bottom_out, marker_x_out,
               marker_score_out, marker_count_out
    );
endinterface

// File: rtl/marker_row_tracker.sv
// marker_row_tracker
// Groups consecutive qualifying lines from count_flips whose coordinates stay
// within COORD_TOL of the previous line into vertical runs. When a run of at
// least MIN_RUN lines ends, one marker candidate (top, bottom, x centre, best
// score) is emitted with a one-cycle valid pulse, and the per-frame marker
// count is advanced.
// Ports:
//   clk_in : system clock
//   rst_in : synchronous active-high reset
//   bus    : marker_row_tracker_if.slave (line results in, marker fields out)
module marker_row_tracker #(
    parameter int unsigned MIN_FLIPS = 4,
    parameter int unsigned MIN_PROB  = 512,
    parameter int unsigned COORD_TOL = 8,
    parameter int unsigned MIN_RUN   = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    marker_row_tracker_if.slave   bus
);

    typedef enum logic {SEARCH, TRACK} state_t;

    state_t      state, state_next;

    logic        done_prev;
    logic [10:0] line_cnt;

    logic [10:0] run_top, run_bottom, run_min, run_max, run_last, run_score, run_len;

    logic        capture;
    logic        qualify;
    logic        continuous;
    logic [10:0] line_index;
    logic [11:0] coord_diff;
    logic [11:0] coord_abs;
    logic [11:0] x_sum;

    logic        start_run, extend_run, close_run, emit;

    assign capture = bus.done_in && !done_prev;
    assign qualify = (bus.number_of_flips_in >= 4'(MIN_FLIPS)) &&
                     (bus.nt_probability_in  >= 11'(MIN_PROB));

    // Zero-extended 12-bit subtraction; the result is read as two's complement.
    assign coord_diff = {1'b0, bus.coord_in} - {1'b0, run_last};
    assign coord_abs  = coord_diff[11] ? (12'd0 - coord_diff) : coord_diff;
    assign continuous = (coord_abs <= 12'(COORD_TOL));

    // A frame start restarts indexing, so a coincident capture is line 0.
    assign line_index = bus.frame_start_in ? 11'd0 : line_cnt;

    assign x_sum = {1'b0, run_min} + {1'b0, run_max};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        extend_run = 1'b0;
        close_run  = 1'b0;

        if (bus.frame_start_in) begin
            // Flush the active run, then evaluate any coincident line from SEARCH.
            close_run  = (state == TRACK);
            state_next = SEARCH;
            if (capture && qualify) begin
                start_run  = 1'b1;
                state_next = TRACK;
            end
        end else if (capture) begin
            case (state)
                SEARCH: begin
                    if (qualify) begin
                        start_run  = 1'b1;
                        state_next = TRACK;
                    end
                end
                TRACK: begin
                    if (qualify && continuous) begin
                        extend_run = 1'b1;
                    end else if (qualify) begin
                        close_run  = 1'b1;
                        start_run  = 1'b1;
                    end else begin
                        close_run  = 1'b1;
                        state_next = SEARCH;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    assign emit = close_run && (run_len >= 11'(MIN_RUN));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            done_prev             <= 1'b0;
            line_cnt              <= '0;
            run_top               <= '0;
            run_bottom            <= '0;
            run_min               <= '0;
            run_max               <= '0;
            run_last              <= '0;
            run_score             <= '0;
            run_len               <= '0;
            bus.marker_valid_out  <= 1'b0;
            bus.marker_top_out    <= '0;
            bus.marker_bottom_out <= '0;
            bus.marker_x_out      <= '0;
            bus.marker_score_out  <= '0;
            bus.marker_count_out  <= '0;
        end else begin
            done_prev <= bus.done_in;

            if (bus.frame_start_in) begin
                line_cnt <= capture ? 11'd1 : 11'd0;
            end else if (capture && (line_cnt != '1)) begin
                line_cnt <= line_cnt + 11'd1;
            end

            // Marker fields are taken from the run as it stood before this line.
            bus.marker_valid_out <= emit;
            if (emit) begin
                bus.marker_top_out    <= run_top;
                bus.marker_bottom_out <= run_bottom;
                bus.marker_x_out      <= x_sum[11:1];
                bus.marker_score_out  <= run_score;
            end

            // A flush emit belongs to the old frame, so the clear wins.
            if (bus.frame_start_in) begin
                bus.marker_count_out <= '0;
            end else if (emit && (bus.marker_count_out != '1)) begin
                bus.marker_count_out <= bus.marker_count_out + 4'd1;
            end

            if (start_run) begin
                run_top    <= line_index;
                run_bottom <= line_index;
                run_min    <= bus.coord_in;
                run_max    <= bus.coord_in;
                run_last   <= bus.coord_in;
                run_score  <= bus.nt_probability_in;
                run_len    <= 11'd1;
            end else if (extend_run) begin
                run_bottom <= line_index;
                run_last   <= bus.coord_in;
                if (bus.coord_in < run_min) begin
                    run_min <= bus.coord_in;
                end
                if (bus.coord_in > run_max) begin
                    run_max <= bus.coord_in;
                end
                if (bus.nt_probability_in > run_score) begin
                    run_score <= bus.nt_probability_in;
                end
                if (run_len != '1) begin
                    run_len <= run_len + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_marker_row_tracker.sv
// tb_marker_row_tracker
// Directed-vector bench for marker_row_tracker with hand-computed expectations.
module tb_marker_row_tracker;

    logic clk_in;
    logic rst_in;
    int   nvec;
    int   nmis;
    int   pulses;

    marker_row_tracker_if bus();

    marker_row_tracker #(
        .MIN_FLIPS (4),
        .MIN_PROB  (512),
        .COORD_TOL (8),
        .MIN_RUN   (6)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Counts marker_valid_out pulses; read only at negedges where valid is low.
    always @(negedge clk_in) begin
        if (bus.marker_valid_out === 1'b1) pulses++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One line result: done high for one cycle, then low for at least one.
    task automatic send_line(input logic [3:0] f, input logic [10:0] c,
                             input logic [10:0] p, input logic fs);
        @(negedge clk_in);
        bus.number_of_flips_in = f;
        bus.coord_in           = c;
        bus.nt_probability_in  = p;
        bus.frame_start_in     = fs;
        bus.done_in            = 1'b1;
        @(negedge clk_in);
        bus.done_in        = 1'b0;
        bus.frame_start_in = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk_in);
        bus.frame_start_in = 1'b1;
        @(negedge clk_in);
        bus.frame_start_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check_marker(input string tag, input logic [10:0] top, input logic [10:0] bot,
                                input logic [10:0] x, input logic [10:0] score, input logic [3:0] cnt);
        check_val({tag, "_valid"}, 32'(bus.marker_valid_out),  32'd1);
        check_val({tag, "_top"},   32'(bus.marker_top_out),    32'(top));
        check_val({tag, "_bot"},   32'(bus.marker_bottom_out), 32'(bot));
        check_val({tag, "_x"},     32'(bus.marker_x_out),      32'(x));
        check_val({tag, "_score"}, 32'(bus.marker_score_out),  32'(score));
        check_val({tag, "_count"}, 32'(bus.marker_count_out),  32'(cnt));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_valid"}, 32'(bus.marker_valid_out),  32'd0);
        check_val({tag, "_top"},   32'(bus.marker_top_out),    32'd0);
        check_val({tag, "_bot"},   32'(bus.marker_bottom_out), 32'd0);
        check_val({tag, "_x"},     32'(bus.marker_x_out),      32'd0);
        check_val({tag, "_score"}, 32'(bus.marker_score_out),  32'd0);
        check_val({tag, "_count"}, 32'(bus.marker_count_out),  32'd0);
    endtask

    initial begin
        nvec   = 0;
        nmis   = 0;
        pulses = 0;

        // Reset with random inputs
        rst_in = 1'b1;
        bus.frame_start_in     = 1'($urandom);
        bus.done_in            = 1'($urandom);
        bus.number_of_flips_in = 4'($urandom);
        bus.coord_in           = 11'($urandom);
        bus.nt_probability_in  = 11'($urandom);
        idle(1);
        bus.done_in  = 1'($urandom);
        bus.coord_in = 11'($urandom);
        idle(1);
        check_zero("reset");
        bus.frame_start_in = 1'b0;
        bus.done_in        = 1'b0;
        rst_in             = 1'b0;
        idle(1);

        // First run after reset starts at index 0
        for (int i = 0; i < 6; i++) send_line(4'd6, 11'd10, 11'd600, 1'b0);
        send_line(4'd0, 11'd10, 11'd600, 1'b0);
        check_marker("first", 11'd0, 11'd5, 11'd10, 11'd600, 4'd1);

        pulse_frame();
        check_val("frame_clear_count", 32'(bus.marker_count_out), 32'd0);

        // Basic run at lines 20..29
        for (int i = 0; i < 20; i++) send_line(4'd1, 11'd0, 11'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            send_line(4'd6, (i % 2 == 0) ? 11'd500 : 11'd504, 11'(600 + (i * 200) / 9), 1'b0);
        send_line(4'd2, 11'd500, 11'd700, 1'b0);
        check_marker("basic", 11'd20, 11'd29, 11'd502, 11'd800, 4'd1);
        idle(1);
        check_val("basic_valid_drop", 32'(bus.marker_valid_out), 32'd0);
        idle(1);
        check_val("basic_pulses", 32'(pulses), 32'd2);

        // Short run: five lines is not enough
        pulse_frame();
        for (int i = 0; i < 5; i++) send_line(4'd6, 11'd100, 11'd600, 1'b0);
        send_line(4'd0, 11'd100, 11'd600, 1'b0);
        idle(2);
        check_val("short_pulses", 32'(pulses), 32'd2);
        check_val("short_count", 32'(bus.marker_count_out), 32'd0);

        // Tolerance (diff 8 continues) and jump (diff 9 restarts), lines 6..18
        for (int i = 0; i < 6; i++)
            send_line(4'd6, (i % 2 == 0) ? 11'd300 : 11'd308, 11'd650, 1'b0);
        send_line(4'd6, 11'd317, 11'd520, 1'b0);
        check_marker("tol1", 11'd6, 11'd11, 11'd304, 11'd650, 4'd1);
        for (int i = 0; i < 5; i++) send_line(4'd6, 11'd317, 11'd530, 1'b0);
        send_line(4'd3, 11'd317, 11'd600, 1'b0);
        check_marker("tol2", 11'd12, 11'd17, 11'd317, 11'd530, 4'd2);

        // Edge detect: a long done level is one capture
        pulse_frame();
        @(negedge clk_in);
        bus.number_of_flips_in = 4'd6;
        bus.coord_in           = 11'd700;
        bus.nt_probability_in  = 11'd600;
        bus.done_in            = 1'b1;
        idle(50);
        bus.done_in = 1'b0;
        idle(1);
        bus.done_in = 1'b1;
        idle(1);
        bus.done_in = 1'b0;
        for (int i = 0; i < 4; i++) send_line(4'd6, 11'd700, 11'd600, 1'b0);
        send_line(4'd0, 11'd700, 11'd600, 1'b0);
        check_marker("edge", 11'd0, 11'd5, 11'd700, 11'd600, 4'd1);

        // Frame flush coincident with a qualifying capture, old run at lines 7..13
        for (int i = 0; i < 7; i++) send_line(4'd6, 11'd900, 11'(700 + i), 1'b0);
        send_line(4'd6, 11'd50, 11'd600, 1'b1);
        check_marker("flush", 11'd7, 11'd13, 11'd900, 11'd706, 4'd0);
        for (int i = 0; i < 5; i++) send_line(4'd6, 11'd50, 11'd600, 1'b0);
        send_line(4'd0, 11'd50, 11'd600, 1'b0);
        check_marker("newframe", 11'd0, 11'd5, 11'd50, 11'd600, 4'd1);
        idle(2);
        check_val("flush_pulses", 32'(pulses), 32'd7);

        // Reset mid-run discards the run
        for (int i = 0; i < 6; i++) send_line(4'd6, 11'd200, 11'd600, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        check_zero("midreset");
        idle(2);
        check_val("midreset_pulses", 32'(pulses), 32'd7);
        for (int i = 0; i < 6; i++) send_line(4'd6, 11'd200, 11'd600, 1'b0);
        send_line(4'd0, 11'd200, 11'd600, 1'b0);
        check_marker("postreset", 11'd0, 11'd5, 11'd200, 11'd600, 4'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/marker_row_tracker.md
Name: marker_row_tracker

Overview:
- Sits directly downstream of count_flips and consumes its per-line results: flip count, coordinate, nt probability and done.
- Groups consecutive qualifying lines with consistent horizontal coordinate into vertical runs.
- When a run of sufficient height ends, emits one marker candidate: top line, bottom line, x centre and best score.
- Per-frame marker counting supports the downstream marker selection logic.

Parameters:
MIN_FLIPS, 4, minimum number_of_flips for a line to qualify
MIN_PROB, 512, minimum nt_probability for a line to qualify
COORD_TOL, 8, max absolute coord difference between consecutive run lines
MIN_RUN, 6, minimum run length in lines for a marker to be emitted

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
frame_start_in  input  1  one-cycle pulse at start of frame
done_in  input  1  count_flips done level; line result is valid on its rising edge
number_of_flips_in  input  4  flips in current line
coord_in  input  11  horizontal coordinate of line's pattern
nt_probability_in  input  11  line score; higher is better
marker_valid_out  output  1  one-cycle pulse, marker fields updated
marker_top_out  output  11  first line index of run
marker_bottom_out  output  11  last line index of run
marker_x_out  output  11  (min_coord+max_coord)>>1 over run
marker_score_out  output  11  max nt_probability over run
marker_count_out  output  4  markers emitted since last frame_start_in, saturating at 15

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_in, sampled at posedge clk_in.
- On reset:
  - all outputs are 0.
  - state is SEARCH.
  - line counter is 0, done_prev is 0, all run registers are 0.
- Line capture: a capture occurs on a cycle where done_in=1 and done_prev=0. Holding done_in high yields exactly one capture.
- Line index:
  - The captured line takes the current line counter value as its index.
  - The counter then increments, 11-bit, saturating at 2047.
- Qualify: number_of_flips_in>=MIN_FLIPS AND nt_probability_in>=MIN_PROB.
- Continuity: |coord_in - last_coord|<=COORD_TOL, computed in 12-bit signed. A difference of exactly COORD_TOL continues the run.
- State SEARCH:
  - A qualifying capture starts a run and moves to TRACK.
  - Starting a run sets: top=bottom=index, min=max=last=coord, score=prob, run_len=1.
- State TRACK, on each capture:
  - Qualifying and continuous: bottom=index, last=coord, update min/max, score=max(score,prob), run_len+1 (saturating at 2047).
  - Qualifying but not continuous: close the run, then start a new run with this line in the same cycle. Stay in TRACK.
  - Not qualifying: close the run and go to SEARCH.
- Close:
  - If run_len>=MIN_RUN, the marker outputs load on the next clock edge and marker_valid_out=1 for exactly that cycle. marker_count_out increments, saturating at 15.
  - A run shorter than MIN_RUN is silently discarded.
- Latency: marker_valid_out rises in the cycle after the capture that ends the run. Marker fields hold their value until the next emit.
- marker_x_out: 12-bit sum of min and max, then >>1, truncated.
- frame_start_in:
  - Flushes an active run: closes it with the usual emit rules, and the emit is not counted in the new frame.
  - Sets marker_count_out=0 and the line counter to 0, then goes to SEARCH.
- frame_start_in and a capture in the same cycle: the flush happens first, then the captured line is evaluated as index 0 of the new frame from SEARCH. The line counter becomes 1.
- rst_in mid-run: the run is discarded with no emit, and all state returns to reset values.

Test Plan:
- Reset: assert rst_in for 2 cycles with random inputs -> all outputs 0. The first capture afterwards gets index 0.
- Basic run:
  - Stimulus: lines 20-29 qualify (flips=6, prob=600..800 ramp, coord alternating 500/504), line 30 has flips=2.
  - Response: one cycle after the line-30 capture, valid=1, top=20, bottom=29, x=502, score=800, count=1.
- Short run: 5 qualifying lines then a non-qualifying line -> valid never asserts, count stays 0.
- Tolerance and jump:
  - Stimulus: coords 300,308,300,308,300,308, then 317 (diff 9, qualifying), then 5 more lines at 317, then a bad line.
  - Response: first emit x=304 with bottom equal to the 6th line. Second emit top equal to the 7th line, x=317.
  - Check that a diff of exactly 8 continues the run.
- Edge detect: done_in held high 50 cycles, then low, then high -> exactly 2 captures. The line counter ends at 2.
- Frame flush: 7 qualifying lines, then frame_start_in coincident with a qualifying capture.
  - Response: flush emit with top/bottom from the old run. count=0, the new run top=0, the line counter becomes 1.
